// File: rtl/hack_pkg.sv
// Shared definitions for the Hack computer: instruction fields, comp/jump
// encodings, memory map and small encoding helpers.
package hack_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 15;

  // Instruction bit-field positions
  localparam int BIT_CI = 15;
  localparam int BIT_A  = 12;
  localparam int C_HI   = 11;
  localparam int C_LO   = 6;
  localparam int D_HI   = 5;
  localparam int D_LO   = 3;
  localparam int J_HI   = 2;
  localparam int J_LO   = 0;

  // Decoded view of a C-instruction (111a cccc ccdd djjj)
  typedef struct packed {
    logic       ci;
    logic [1:0] rsvd;
    logic       a;
    logic       zx;
    logic       nx;
    logic       zy;
    logic       ny;
    logic       f;
    logic       no;
    logic       dst_a;
    logic       dst_d;
    logic       dst_m;
    logic       j_lt;
    logic       j_eq;
    logic       j_gt;
  } instr_t;

  typedef enum logic [2:0] {
    J_NONE = 3'b000,
    J_GT   = 3'b001,
    J_EQ   = 3'b010,
    J_GE   = 3'b011,
    J_LT   = 3'b100,
    J_NE   = 3'b101,
    J_LE   = 3'b110,
    J_MP   = 3'b111
  } jump_e;

  // Destination field values (d1 d2 d3 = A D M)
  localparam logic [2:0] DST_NONE = 3'b000;
  localparam logic [2:0] DST_M    = 3'b001;
  localparam logic [2:0] DST_D    = 3'b010;
  localparam logic [2:0] DST_A    = 3'b100;
  localparam logic [2:0] DST_AM   = 3'b101;

  // comp encodings, {a, c1..c6}
  localparam logic [6:0] COMP_ZERO   = 7'b0101010;
  localparam logic [6:0] COMP_ONE    = 7'b0111111;
  localparam logic [6:0] COMP_NEG1   = 7'b0111010;
  localparam logic [6:0] COMP_D      = 7'b0001100;
  localparam logic [6:0] COMP_A      = 7'b0110000;
  localparam logic [6:0] COMP_NOT_D  = 7'b0001101;
  localparam logic [6:0] COMP_NOT_A  = 7'b0110001;
  localparam logic [6:0] COMP_NEG_D  = 7'b0001111;
  localparam logic [6:0] COMP_NEG_A  = 7'b0110011;
  localparam logic [6:0] COMP_D_P1   = 7'b0011111;
  localparam logic [6:0] COMP_A_P1   = 7'b0110111;
  localparam logic [6:0] COMP_D_M1   = 7'b0001110;
  localparam logic [6:0] COMP_A_M1   = 7'b0110010;
  localparam logic [6:0] COMP_D_PL_A = 7'b0000010;
  localparam logic [6:0] COMP_D_MI_A = 7'b0010011;
  localparam logic [6:0] COMP_A_MI_D = 7'b0000111;
  localparam logic [6:0] COMP_D_AND_A= 7'b0000000;
  localparam logic [6:0] COMP_D_OR_A = 7'b0010101;
  localparam logic [6:0] COMP_M      = 7'b1110000;
  localparam logic [6:0] COMP_NOT_M  = 7'b1110001;
  localparam logic [6:0] COMP_NEG_M  = 7'b1110011;
  localparam logic [6:0] COMP_M_P1   = 7'b1110111;
  localparam logic [6:0] COMP_M_M1   = 7'b1110010;
  localparam logic [6:0] COMP_D_PL_M = 7'b1000010;
  localparam logic [6:0] COMP_D_MI_M = 7'b1010011;
  localparam logic [6:0] COMP_M_MI_D = 7'b1000111;
  localparam logic [6:0] COMP_D_AND_M= 7'b1000000;
  localparam logic [6:0] COMP_D_OR_M = 7'b1010101;

  // Memory map
  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;

  function automatic logic jump_taken(input jump_e j, input logic ng, input logic zr);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

  function automatic logic [15:0] c_inst(input logic [6:0] comp, input logic [2:0] dest,
                                         input logic [2:0] jmp);
    return {3'b111, comp, dest, jmp};
  endfunction

  function automatic logic [15:0] a_inst(input logic [14:0] val);
    return {1'b0, val};
  endfunction

endpackage

// File: rtl/computer_if.sv
// CPU-to-memory bus of the Hack computer: instruction fetch plus data access.
interface computer_if;
  import hack_pkg::*;

  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [DATA_W-1:0] rdata;

  modport master (output pc, addr, wdata, we, input instr, rdata);
  modport slave  (input pc, addr, wdata, we, output instr, rdata);
endinterface

// File: rtl/computer_cpu.sv
// Hack CPU core: A, D and PC registers, instruction decode, ALU and jump logic.
module computer_cpu
  import hack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  computer_if.master  bus
);

  logic [DATA_W-1:0] a_q, a_d, d_q, d_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] y, alu_out;
  logic              zr, ng;
  instr_t            ins;
  logic [1:0]        unused_rsvd;

  assign ins         = instr_t'(bus.instr);
  assign unused_rsvd = ins.rsvd;
  assign y           = ins.a ? bus.rdata : a_q;

  hack_alu u_alu (
    .x_i   (d_q),
    .y_i   (y),
    .zx_i  (ins.zx),
    .nx_i  (ins.nx),
    .zy_i  (ins.zy),
    .ny_i  (ins.ny),
    .f_i   (ins.f),
    .no_i  (ins.no),
    .out_o (alu_out),
    .zr_o  (zr),
    .ng_o  (ng)
  );

  // Next-state for A, D and PC; jump target uses A from before the edge
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + 15'd1;
    if (!ins.ci) begin
      a_d = bus.instr;
    end else begin
      if (ins.dst_a) a_d = alu_out;
      if (ins.dst_d) d_d = alu_out;
      if (jump_taken(jump_e'({ins.j_lt, ins.j_eq, ins.j_gt}), ng, zr))
        pc_d = a_q[PC_W-1:0];
    end
  end

  // Architectural register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= '0;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  // Memory write addresses the pre-edge A; reset suppresses any pending write
  assign bus.pc    = pc_q;
  assign bus.addr  = a_q;
  assign bus.wdata = alu_out;
  assign bus.we    = ins.ci & ins.dst_m & ~reset;

endmodule

// File: rtl/computer_mem.sv
// Instruction ROM, data RAM and (with SCREEN_EN defined) screen RAM.
// All reads are combinational; RAM writes happen on the rising edge.
module computer_rom #(
  parameter int DEPTH = 32768
) (
  input  logic [14:0] addr_i,
  output logic [15:0] data_o
);
  logic [15:0] _rom [0:DEPTH-1];

  assign data_o = _rom[addr_i];
endmodule

module computer_ram #(
  parameter int DEPTH = 16384
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [13:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);
  logic [15:0] _ram [0:DEPTH-1];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we_i) _ram[addr_i] <= wdata_i;
  end

  assign rdata_o = _ram[addr_i];
endmodule

`ifdef SCREEN_EN
module computer_screen (
  input  logic        clk,
  input  logic        we_i,
  input  logic [12:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);
  logic [15:0] _screen [0:8191];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we_i) _screen[addr_i] <= wdata_i;
  end

  assign rdata_o = _screen[addr_i];
endmodule
`endif

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zx/nx/zy/ny preconditioning, add or and, optional invert.
module hack_alu
  import hack_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic              zx_i,
  input  logic              nx_i,
  input  logic              zy_i,
  input  logic              ny_i,
  input  logic              f_i,
  input  logic              no_i,
  output logic [DATA_W-1:0] out_o,
  output logic              zr_o,
  output logic              ng_o
);

  logic [DATA_W-1:0] xa, ya, fo;

  // Operand conditioning, function select and output inversion
  always_comb begin
    xa = zx_i ? '0 : x_i;
    if (nx_i) xa = ~xa;
    ya = zy_i ? '0 : y_i;
    if (ny_i) ya = ~ya;
    fo = f_i ? (xa + ya) : (xa & ya);
    out_o = no_i ? ~fo : fo;
  end

  assign zr_o = (out_o == '0);
  assign ng_o = out_o[DATA_W-1];

endmodule

// File: rtl/computer.sv
// Hack computer top: CPU, instruction ROM and data memory with address decode.
// Optional screen RAM at 0x4000-0x5FFF is built when SCREEN_EN is defined;
// otherwise that range, the keyboard and everything above read 0 and ignore writes.
module computer
  import hack_pkg::*;
#(
  parameter int ROM_DEPTH = 32768,
  parameter int RAM_DEPTH = 16384
) (
  input logic clk,
  input logic reset
);

  computer_if bus ();

  logic [DATA_W-1:0] rom_data, ram_rdata;
  logic              ram_sel;

  computer_cpu u_cpu (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  computer_rom #(.DEPTH(ROM_DEPTH)) u_rom (
    .addr_i (bus.pc),
    .data_o (rom_data)
  );

  assign bus.instr = rom_data;
  assign ram_sel   = (bus.addr[15:14] == RAM_BASE[15:14]);

  computer_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (bus.we & ram_sel),
    .addr_i  (bus.addr[13:0]),
    .wdata_i (bus.wdata),
    .rdata_o (ram_rdata)
  );

`ifdef SCREEN_EN
  logic              scr_sel;
  logic [DATA_W-1:0] scr_rdata;

  assign scr_sel = (bus.addr[15:13] == SCREEN_BASE[15:13]);

  computer_screen u_screen (
    .clk     (clk),
    .we_i    (bus.we & scr_sel),
    .addr_i  (bus.addr[12:0]),
    .wdata_i (bus.wdata),
    .rdata_o (scr_rdata)
  );
`endif

  // Read-data mux; unmapped addresses (keyboard and above) read as zero
  always_comb begin
    bus.rdata = '0;
    if (ram_sel) bus.rdata = ram_rdata;
`ifdef SCREEN_EN
    else if (scr_sel) bus.rdata = scr_rdata;
`endif
  end

endmodule

// File: tb/tb_computer.sv
// Directed bench for the Hack computer: programs are loaded into u_rom and
// data into u_ram through the backdoor, then registers and RAM are inspected.
module tb_computer;
  import hack_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  computer dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) dut.u_rom._rom[i] = 16'h0000;
  endtask

  task automatic test_reset();
    clear_rom();
    dut.u_rom._rom[0] = c_inst(COMP_ONE, DST_M, J_NONE);
    dut.u_ram._ram[0] <= 16'hBEEF;
    reset = 1'b1;
    tick(2);
    n_tests++;
    if (dut.u_cpu.pc_q !== 15'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h want 0000", dut.u_cpu.pc_q);
    end
    n_tests++;
    if (dut.u_cpu.a_q !== 16'h0) begin
      n_fail++; $display("FAIL reset_a: got %h want 0000", dut.u_cpu.a_q);
    end
    n_tests++;
    if (dut.u_cpu.d_q !== 16'h0) begin
      n_fail++; $display("FAIL reset_d: got %h want 0000", dut.u_cpu.d_q);
    end
    n_tests++;
    if (dut.u_ram._ram[0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL reset_wr_block: got %h want beef", dut.u_ram._ram[0]);
    end
    reset = 1'b0;
    tick(1);
    n_tests++;
    if (dut.u_ram._ram[0] !== 16'h0001) begin
      n_fail++; $display("FAIL post_reset_wr: got %h want 0001", dut.u_ram._ram[0]);
    end
  endtask

  task automatic test_max();
    logic [15:0] r0 [3];
    logic [15:0] r1 [3];
    logic [15:0] ex [3];
    r0 = '{16'd2, 16'd566, 16'd5};
    r1 = '{16'd3, 16'd3,   16'd5};
    ex = '{16'd3, 16'd566, 16'd5};
    clear_rom();
    dut.u_rom._rom[0]  = a_inst(15'd0);
    dut.u_rom._rom[1]  = c_inst(COMP_M, DST_D, J_NONE);
    dut.u_rom._rom[2]  = a_inst(15'd1);
    dut.u_rom._rom[3]  = c_inst(COMP_D_MI_M, DST_D, J_NONE);
    dut.u_rom._rom[4]  = a_inst(15'd10);
    dut.u_rom._rom[5]  = c_inst(COMP_D, DST_NONE, J_GT);
    dut.u_rom._rom[6]  = a_inst(15'd1);
    dut.u_rom._rom[7]  = c_inst(COMP_M, DST_D, J_NONE);
    dut.u_rom._rom[8]  = a_inst(15'd12);
    dut.u_rom._rom[9]  = c_inst(COMP_ZERO, DST_NONE, J_MP);
    dut.u_rom._rom[10] = a_inst(15'd0);
    dut.u_rom._rom[11] = c_inst(COMP_M, DST_D, J_NONE);
    dut.u_rom._rom[12] = a_inst(15'd2);
    dut.u_rom._rom[13] = c_inst(COMP_D, DST_M, J_NONE);
    dut.u_rom._rom[14] = a_inst(15'd14);
    dut.u_rom._rom[15] = c_inst(COMP_ZERO, DST_NONE, J_MP);
    for (int v = 0; v < 3; v++) begin
      dut.u_ram._ram[0] <= r0[v];
      dut.u_ram._ram[1] <= r1[v];
      dut.u_ram._ram[2] <= 16'hDEAD;
      do_reset(v == 0 ? 5 : 1);
      tick(50);
      n_tests++;
      if (dut.u_ram._ram[2] !== ex[v]) begin
        n_fail++; $display("FAIL max_%0d: got %0d want %0d", v, dut.u_ram._ram[2], ex[v]);
      end
      n_tests++;
      if (!(dut.u_cpu.pc_q === 15'd14 || dut.u_cpu.pc_q === 15'd15)) begin
        n_fail++; $display("FAIL max_halt_%0d: got pc %0d want 14 or 15", v, dut.u_cpu.pc_q);
      end
    end
  endtask

  task automatic test_alu();
    logic [6:0]  comps [7];
    logic [15:0] ex    [7];
    comps = '{COMP_D_P1, COMP_D_MI_A, COMP_A_MI_D, COMP_D_AND_A, COMP_D_OR_A,
              COMP_NOT_D, COMP_NEG_D};
    ex    = '{16'h0012, 16'h000E, 16'hFFF2, 16'h0001, 16'h0013, 16'hFFEE, 16'hFFEF};
    for (int i = 0; i < 7; i++) begin
      clear_rom();
      dut.u_rom._rom[0] = a_inst(15'h0011);
      dut.u_rom._rom[1] = c_inst(COMP_A, DST_D, J_NONE);
      dut.u_rom._rom[2] = a_inst(15'h0003);
      dut.u_rom._rom[3] = c_inst(comps[i], DST_D, J_NONE);
      do_reset(1);
      tick(4);
      n_tests++;
      if (dut.u_cpu.d_q !== ex[i]) begin
        n_fail++; $display("FAIL alu_%0d: got %h want %h", i, dut.u_cpu.d_q, ex[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [6:0] dc   [3];
    logic [7:0] mask [3];
    logic [7:0] m;
    logic [14:0] exp_pc;
    dc   = '{COMP_NEG1, COMP_ZERO, COMP_ONE};
    mask = '{8'b1111_0000, 8'b1100_1100, 8'b1010_1010};
    for (int di = 0; di < 3; di++) begin
      for (int j = 0; j < 8; j++) begin
        clear_rom();
        dut.u_rom._rom[0] = c_inst(dc[di], DST_D, J_NONE);
        dut.u_rom._rom[1] = a_inst(15'h0100);
        dut.u_rom._rom[2] = c_inst(COMP_D, DST_NONE, 3'(j));
        do_reset(1);
        tick(3);
        m = mask[di];
        exp_pc = m[j] ? 15'h0100 : 15'h0003;
        n_tests++;
        if (dut.u_cpu.pc_q !== exp_pc) begin
          n_fail++;
          $display("FAIL jump_d%0d_j%0d: got pc %h want %h", di, j, dut.u_cpu.pc_q, exp_pc);
        end
      end
    end
    // A=-1 jumps to 0x7FFF; the next instruction wraps PC to 0
    clear_rom();
    dut.u_rom._rom[0]       = c_inst(COMP_NEG1, DST_A, J_NONE);
    dut.u_rom._rom[1]       = c_inst(COMP_ZERO, DST_NONE, J_MP);
    dut.u_rom._rom[15'h7FFF] = c_inst(COMP_ONE, DST_D, J_NONE);
    do_reset(1);
    tick(2);
    n_tests++;
    if (dut.u_cpu.pc_q !== 15'h7FFF) begin
      n_fail++; $display("FAIL jump_top: got pc %h want 7fff", dut.u_cpu.pc_q);
    end
    tick(1);
    n_tests++;
    if (dut.u_cpu.pc_q !== 15'h0000) begin
      n_fail++; $display("FAIL pc_wrap: got pc %h want 0000", dut.u_cpu.pc_q);
    end
    n_tests++;
    if (dut.u_cpu.d_q !== 16'h0001) begin
      n_fail++; $display("FAIL wrap_exec: got d %h want 0001", dut.u_cpu.d_q);
    end
  endtask

  task automatic test_am();
    clear_rom();
    dut.u_rom._rom[0] = a_inst(15'd7);
    dut.u_rom._rom[1] = c_inst(COMP_M_P1, DST_AM, J_NONE);
    dut.u_ram._ram[7]  <= 16'd9;
    dut.u_ram._ram[10] <= 16'h0055;
    do_reset(1);
    tick(2);
    n_tests++;
    if (dut.u_ram._ram[7] !== 16'd10) begin
      n_fail++; $display("FAIL am_ram7: got %0d want 10", dut.u_ram._ram[7]);
    end
    n_tests++;
    if (dut.u_cpu.a_q !== 16'd10) begin
      n_fail++; $display("FAIL am_a: got %0d want 10", dut.u_cpu.a_q);
    end
    n_tests++;
    if (dut.u_ram._ram[10] !== 16'h0055) begin
      n_fail++; $display("FAIL am_old_a: got %h want 0055", dut.u_ram._ram[10]);
    end
  endtask

  task automatic test_memmap();
    logic [15:0] exp_scr;
    // keyboard address: write ignored, reads 0, no alias into RAM
    clear_rom();
    dut.u_rom._rom[0] = c_inst(COMP_NEG1, DST_D, J_NONE);
    dut.u_rom._rom[1] = a_inst(15'h6000);
    dut.u_rom._rom[2] = c_inst(COMP_ONE, DST_M, J_NONE);
    dut.u_rom._rom[3] = c_inst(COMP_M, DST_D, J_NONE);
    dut.u_ram._ram[14'h2000] <= 16'h1234;
    do_reset(1);
    tick(4);
    n_tests++;
    if (dut.u_cpu.d_q !== 16'h0000) begin
      n_fail++; $display("FAIL kbd_read: got %h want 0000", dut.u_cpu.d_q);
    end
    n_tests++;
    if (dut.u_ram._ram[14'h2000] !== 16'h1234) begin
      n_fail++; $display("FAIL kbd_alias: got %h want 1234", dut.u_ram._ram[14'h2000]);
    end
    // screen range
    dut.u_rom._rom[1] = a_inst(15'h4000);
    dut.u_ram._ram[0] <= 16'h4321;
    do_reset(1);
    tick(4);
`ifdef SCREEN_EN
    exp_scr = 16'h0001;
`else
    exp_scr = 16'h0000;
`endif
    n_tests++;
    if (dut.u_cpu.d_q !== exp_scr) begin
      n_fail++; $display("FAIL screen_read: got %h want %h", dut.u_cpu.d_q, exp_scr);
    end
    n_tests++;
    if (dut.u_ram._ram[0] !== 16'h4321) begin
      n_fail++; $display("FAIL screen_alias: got %h want 4321", dut.u_ram._ram[0]);
    end
  endtask

  task automatic test_midreset();
    clear_rom();
    dut.u_rom._rom[0] = a_inst(15'd7);
    dut.u_rom._rom[1] = c_inst(COMP_A, DST_D, J_NONE);
    dut.u_rom._rom[2] = c_inst(COMP_M_P1, DST_M, J_NONE);
    dut.u_rom._rom[3] = a_inst(15'd0);
    dut.u_rom._rom[4] = c_inst(COMP_ZERO, DST_NONE, J_MP);
    dut.u_ram._ram[7] <= 16'h0020;
    do_reset(1);
    tick(7);
    n_tests++;
    if (dut.u_ram._ram[7] !== 16'h0021 || dut.u_cpu.pc_q !== 15'd2) begin
      n_fail++;
      $display("FAIL loop_state: got ram7 %h pc %0d want 0021 pc 2",
               dut.u_ram._ram[7], dut.u_cpu.pc_q);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_tests++;
    if (dut.u_cpu.pc_q !== 15'h0) begin
      n_fail++; $display("FAIL mid_pc: got %h want 0000", dut.u_cpu.pc_q);
    end
    n_tests++;
    if (dut.u_cpu.a_q !== 16'h0 || dut.u_cpu.d_q !== 16'h0) begin
      n_fail++; $display("FAIL mid_ad: got a %h d %h want 0000 0000", dut.u_cpu.a_q, dut.u_cpu.d_q);
    end
    n_tests++;
    if (dut.u_ram._ram[7] !== 16'h0021) begin
      n_fail++; $display("FAIL mid_nowrite: got %h want 0021", dut.u_ram._ram[7]);
    end
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    n_tests = 0;
    n_fail  = 0;
    @(negedge clk);
    test_reset();
    test_max();
    test_alu();
    test_jump();
    test_am();
    test_memmap();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
